// File: rtl/mem_controller_pkg.sv
// Shared widths and op codes for the LSB/ROB memory controller slice.
package mem_controller_pkg;

    localparam int XLEN           = 32;
    localparam int INST_OP_WIDTH  = 6;
    localparam int ROB_SIZE_WIDTH = 4;

    // Memory op codes (load and store subsets)
    localparam logic [INST_OP_WIDTH-1:0] OP_LB  = 6'd10;
    localparam logic [INST_OP_WIDTH-1:0] OP_LH  = 6'd11;
    localparam logic [INST_OP_WIDTH-1:0] OP_LW  = 6'd12;
    localparam logic [INST_OP_WIDTH-1:0] OP_LBU = 6'd13;
    localparam logic [INST_OP_WIDTH-1:0] OP_LHU = 6'd14;
    localparam logic [INST_OP_WIDTH-1:0] OP_SB  = 6'd15;
    localparam logic [INST_OP_WIDTH-1:0] OP_SH  = 6'd16;
    localparam logic [INST_OP_WIDTH-1:0] OP_SW  = 6'd17;

endpackage

// File: rtl/mem_controller_load_extend.sv
// Sign/zero extension of a little-endian assembled load value.
module mem_load_extend
    import mem_controller_pkg::*;
(
    input  logic [INST_OP_WIDTH-1:0] op,
    input  logic [XLEN-1:0]          raw,
    output logic [XLEN-1:0]          result
);

    // Byte/half loads extend from their top bit, word loads pass through
    always_comb begin
        result = raw;
        case (op)
            OP_LB:   result = {{24{raw[7]}}, raw[7:0]};
            OP_LBU:  result = {24'h0, raw[7:0]};
            OP_LH:   result = {{16{raw[15]}}, raw[15:0]};
            OP_LHU:  result = {16'h0, raw[15:0]};
            default: result = raw;
        endcase
    end

endmodule

// File: rtl/mem_controller.sv
// Serialises LSB loads and ROB committed stores onto a byte-wide RAM/IO port.
module mem_controller
    import mem_controller_pkg::*;
#(
    parameter logic [31:0] IO_BASE = 32'h30000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      flush,
    input  logic                      io_buffer_full,
    input  logic                      lsb_mem_enable,
    input  logic [INST_OP_WIDTH-1:0]  lsb_mem_op,
    input  logic [XLEN-1:0]           lsb_mem_addr,
    input  logic [ROB_SIZE_WIDTH-1:0] lsb_mem_id,
    input  logic                      rob_mem_enable,
    input  logic [INST_OP_WIDTH-1:0]  rob_mem_op,
    input  logic [XLEN-1:0]           rob_mem_addr,
    input  logic [XLEN-1:0]           rob_mem_data,
    input  logic [7:0]                mem_din,
    output logic                      mem_busy,
    output logic                      mem_data_ready,
    output logic [XLEN-1:0]           mem_data,
    output logic [ROB_SIZE_WIDTH-1:0] mem_id,
    output logic                      mem_store_done,
    output logic [XLEN-1:0]           mem_a,
    output logic [7:0]                mem_dout,
    output logic                      mem_wr
);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_LOAD       = 2'd1;
    localparam logic [1:0] S_STORE      = 2'd2;
    localparam logic [1:0] S_STORE_WAIT = 2'd3;

    function automatic logic [2:0] byte_count(input logic [INST_OP_WIDTH-1:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: byte_count = 3'd1;
            OP_LH, OP_LHU, OP_SH: byte_count = 3'd2;
            default:              byte_count = 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] store_byte(input logic [XLEN-1:0] d, input logic [1:0] k);
        case (k)
            2'd0:    store_byte = d[7:0];
            2'd1:    store_byte = d[15:8];
            2'd2:    store_byte = d[23:16];
            default: store_byte = d[31:24];
        endcase
    endfunction

    logic [1:0]                state;
    logic [2:0]                cnt;
    logic [INST_OP_WIDTH-1:0]  op_q;
    logic [XLEN-1:0]           addr_q;
    logic [XLEN-1:0]           data_q;
    logic [XLEN-1:0]           raw_q;
    logic [ROB_SIZE_WIDTH-1:0] id_q;
    logic                      pend_vld;
    logic [INST_OP_WIDTH-1:0]  pend_op;
    logic [XLEN-1:0]           pend_addr;
    logic [ROB_SIZE_WIDTH-1:0] pend_id;

    logic [2:0]                n_q;
    logic                      is_io_q;
    logic                      rob_is_io;
    logic                      take_pend;
    logic                      take_new;
    logic                      pend_set;
    logic [INST_OP_WIDTH-1:0]  ld_op;
    logic [XLEN-1:0]           ld_addr;
    logic [ROB_SIZE_WIDTH-1:0] ld_id;
    logic [XLEN-1:0]           raw_next;
    logic [XLEN-1:0]           ext_data;

    assign n_q       = byte_count(op_q);
    assign is_io_q   = (addr_q[17:16] == IO_BASE[17:16]);
    assign rob_is_io = (rob_mem_addr[17:16] == IO_BASE[17:16]);
    // A waiting store always wins the port; a flush kills any load start
    assign take_pend = (state == S_IDLE) && !rob_mem_enable && pend_vld && !flush;
    assign take_new  = (state == S_IDLE) && !rob_mem_enable && !pend_vld && lsb_mem_enable && !flush;
    assign pend_set  = lsb_mem_enable && !flush && !take_new;
    assign ld_op     = pend_vld ? pend_op   : lsb_mem_op;
    assign ld_addr   = pend_vld ? pend_addr : lsb_mem_addr;
    assign ld_id     = pend_vld ? pend_id   : lsb_mem_id;
    assign mem_busy  = (state != S_IDLE) || pend_vld || lsb_mem_enable || rob_mem_enable;

    // Merge the byte arriving this cycle so the final byte lands in the result directly
    always_comb begin
        raw_next = raw_q;
        case (cnt)
            3'd2:    raw_next[7:0]   = mem_din;
            3'd3:    raw_next[15:8]  = mem_din;
            3'd4:    raw_next[23:16] = mem_din;
            3'd5:    raw_next[31:24] = mem_din;
            default: raw_next = raw_q;
        endcase
    end

    mem_load_extend u_extend (
        .op     (op_q),
        .raw    (raw_next),
        .result (ext_data)
    );

    // Controller FSM, pending-load slot and registered RAM/result outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            cnt            <= 3'd0;
            op_q           <= '0;
            addr_q         <= '0;
            data_q         <= '0;
            raw_q          <= '0;
            id_q           <= '0;
            pend_vld       <= 1'b0;
            pend_op        <= '0;
            pend_addr      <= '0;
            pend_id        <= '0;
            mem_data_ready <= 1'b0;
            mem_data       <= '0;
            mem_id         <= '0;
            mem_store_done <= 1'b0;
            mem_a          <= '0;
            mem_dout       <= 8'h00;
            mem_wr         <= 1'b0;
        end else if (rdy) begin
            mem_data_ready <= 1'b0;
            mem_store_done <= 1'b0;
            mem_wr         <= 1'b0;
            if (flush) begin
                pend_vld <= 1'b0;
            end else begin
                if (take_pend) pend_vld <= 1'b0;
                if (pend_set) begin
                    pend_vld  <= 1'b1;
                    pend_op   <= lsb_mem_op;
                    pend_addr <= lsb_mem_addr;
                    pend_id   <= lsb_mem_id;
                end
            end
            case (state)
                S_IDLE: begin
                    if (rob_mem_enable) begin
                        op_q   <= rob_mem_op;
                        addr_q <= rob_mem_addr;
                        data_q <= rob_mem_data;
                        if (rob_is_io && io_buffer_full) begin
                            state <= S_STORE_WAIT;
                            cnt   <= 3'd0;
                        end else begin
                            state    <= S_STORE;
                            mem_a    <= rob_mem_addr;
                            mem_dout <= rob_mem_data[7:0];
                            mem_wr   <= 1'b1;
                            cnt      <= 3'd1;
                        end
                    end else if (take_pend || take_new) begin
                        state  <= S_LOAD;
                        op_q   <= ld_op;
                        addr_q <= ld_addr;
                        id_q   <= ld_id;
                        mem_a  <= ld_addr;
                        cnt    <= 3'd1;
                    end
                end
                S_LOAD: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        if (cnt < n_q) mem_a <= addr_q + {29'b0, cnt};
                        if (cnt >= 3'd2) raw_q <= raw_next;
                        if (cnt == n_q + 3'd1) begin
                            mem_data_ready <= 1'b1;
                            mem_data       <= ext_data;
                            mem_id         <= id_q;
                            state          <= S_IDLE;
                        end
                        cnt <= cnt + 3'd1;
                    end
                end
                default: begin
                    if (cnt == n_q) begin
                        mem_store_done <= 1'b1;
                        state          <= S_IDLE;
                    end else if (is_io_q && io_buffer_full) begin
                        state <= S_STORE_WAIT;
                    end else begin
                        state    <= S_STORE;
                        mem_a    <= addr_q + {29'b0, cnt};
                        mem_dout <= store_byte(data_q, cnt[1:0]);
                        mem_wr   <= 1'b1;
                        cnt      <= cnt + 3'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_controller.sv
// Directed bench for mem_controller with a byte RAM model.
module tb_mem_controller;
    import mem_controller_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic                      rdy = 1'b1;
    logic                      flush = 1'b0;
    logic                      io_buffer_full = 1'b0;
    logic                      lsb_mem_enable = 1'b0;
    logic [INST_OP_WIDTH-1:0]  lsb_mem_op = '0;
    logic [XLEN-1:0]           lsb_mem_addr = '0;
    logic [ROB_SIZE_WIDTH-1:0] lsb_mem_id = '0;
    logic                      rob_mem_enable = 1'b0;
    logic [INST_OP_WIDTH-1:0]  rob_mem_op = '0;
    logic [XLEN-1:0]           rob_mem_addr = '0;
    logic [XLEN-1:0]           rob_mem_data = '0;
    logic [7:0]                mem_din = 8'h00;
    logic                      mem_busy;
    logic                      mem_data_ready;
    logic [XLEN-1:0]           mem_data;
    logic [ROB_SIZE_WIDTH-1:0] mem_id;
    logic                      mem_store_done;
    logic [XLEN-1:0]           mem_a;
    logic [7:0]                mem_dout;
    logic                      mem_wr;

    int passed = 0;
    int total  = 0;

    logic [7:0]  ram [logic [31:0]];
    logic [39:0] wr_log [$];

    mem_controller dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .io_buffer_full(io_buffer_full),
        .lsb_mem_enable(lsb_mem_enable), .lsb_mem_op(lsb_mem_op), .lsb_mem_addr(lsb_mem_addr),
        .lsb_mem_id(lsb_mem_id), .rob_mem_enable(rob_mem_enable), .rob_mem_op(rob_mem_op),
        .rob_mem_addr(rob_mem_addr), .rob_mem_data(rob_mem_data), .mem_din(mem_din),
        .mem_busy(mem_busy), .mem_data_ready(mem_data_ready), .mem_data(mem_data),
        .mem_id(mem_id), .mem_store_done(mem_store_done), .mem_a(mem_a),
        .mem_dout(mem_dout), .mem_wr(mem_wr)
    );

    always #5 clk = ~clk;

    // RAM: one-cycle read latency, write on mem_wr
    always @(posedge clk) begin
        mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
        if (mem_wr) begin
            ram[mem_a] = mem_dout;
            wr_log.push_back({mem_a, mem_dout});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_load(input logic [INST_OP_WIDTH-1:0] op, input logic [31:0] addr,
                            input logic [3:0] id, input logic [31:0] exp_data,
                            input int exp_lat, input string name);
        int n;
        lsb_mem_op = op; lsb_mem_addr = addr; lsb_mem_id = id; lsb_mem_enable = 1'b1;
        #1;
        total++;
        if (mem_busy !== 1'b1) $display("FAIL %s_busy got %b want 1", name, mem_busy);
        else passed++;
        tick();
        lsb_mem_enable = 1'b0;
        n = 0;
        while (mem_data_ready !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        total++;
        if (n !== exp_lat) $display("FAIL %s_latency got %0d want %0d", name, n, exp_lat);
        else passed++;
        total++;
        if (mem_data !== exp_data) $display("FAIL %s_data got %h want %h", name, mem_data, exp_data);
        else passed++;
        total++;
        if (mem_id !== id) $display("FAIL %s_id got %0d want %0d", name, mem_id, id);
        else passed++;
        tick();
        total++;
        if (mem_data_ready !== 1'b0) $display("FAIL %s_pulse got %b want 0", name, mem_data_ready);
        else passed++;
    endtask

    task automatic test_reset();
        tick(); tick();
        total++;
        if ({mem_data_ready, mem_store_done, mem_wr, mem_busy} !== 4'b0 ||
            mem_a !== 32'h0 || mem_data !== 32'h0 || mem_dout !== 8'h0 || mem_id !== 4'h0)
            $display("FAIL reset_outputs got %b%b%b%b a=%h d=%h want all zero",
                     mem_data_ready, mem_store_done, mem_wr, mem_busy, mem_a, mem_data);
        else passed++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_loads();
        run_load(OP_LW,  32'h1000, 4'd5, 32'h44332211, 5, "lw");
        run_load(OP_LB,  32'h20,   4'd1, 32'hFFFFFF80, 2, "lb");
        run_load(OP_LBU, 32'h20,   4'd2, 32'h00000080, 2, "lbu");
        run_load(OP_LH,  32'h40,   4'd3, 32'hFFFF8001, 3, "lh");
    endtask

    task automatic test_back_to_back();
        int n;
        int done_cnt;
        int done_at;
        int rdy_at;
        wr_log.delete();
        rob_mem_op = OP_SW; rob_mem_addr = 32'h2000; rob_mem_data = 32'hDEADBEEF; rob_mem_enable = 1'b1;
        lsb_mem_op = OP_LW; lsb_mem_addr = 32'h2000; lsb_mem_id = 4'd7; lsb_mem_enable = 1'b1;
        tick();
        rob_mem_enable = 1'b0; lsb_mem_enable = 1'b0;
        done_cnt = 0; done_at = -1; rdy_at = -1;
        for (n = 0; n < 20 && rdy_at < 0; n++) begin
            if (mem_store_done === 1'b1) begin done_cnt++; done_at = n; end
            if (mem_data_ready === 1'b1) rdy_at = n;
            if (rdy_at < 0) tick();
        end
        total++;
        if (wr_log.size() !== 4) $display("FAIL b2b_write_count got %0d want 4", wr_log.size());
        else passed++;
        if (wr_log.size() == 4) begin
            total++;
            if (wr_log[0] !== 40'h00002000EF || wr_log[1] !== 40'h00002001BE ||
                wr_log[2] !== 40'h00002002AD || wr_log[3] !== 40'h00002003DE)
                $display("FAIL b2b_write_bytes got %h %h %h %h want 2000ef 2001be 2002ad 2003de",
                         wr_log[0], wr_log[1], wr_log[2], wr_log[3]);
            else passed++;
        end
        total++;
        if (done_cnt !== 1 || done_at !== 4) $display("FAIL b2b_store_done got %0d@%0d want 1@4", done_cnt, done_at);
        else passed++;
        total++;
        if (rdy_at !== 10 || mem_data !== 32'hDEADBEEF || mem_id !== 4'd7)
            $display("FAIL b2b_load got %h id %0d @%0d want deadbeef id 7 @10", mem_data, mem_id, rdy_at);
        else passed++;
        tick();
    endtask

    task automatic test_flush();
        int seen;
        lsb_mem_op = OP_LW; lsb_mem_addr = 32'h1000; lsb_mem_id = 4'd3; lsb_mem_enable = 1'b1;
        tick();
        lsb_mem_enable = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++;
        if (mem_busy !== 1'b0 || mem_data_ready !== 1'b0)
            $display("FAIL flush_idle got busy %b ready %b want 0 0", mem_busy, mem_data_ready);
        else passed++;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (mem_data_ready === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) $display("FAIL flush_no_ready got %0d pulses want 0", seen);
        else passed++;
    endtask

    task automatic test_io_store();
        rob_mem_op = OP_SB; rob_mem_addr = 32'h30000; rob_mem_data = 32'h41; rob_mem_enable = 1'b1;
        io_buffer_full = 1'b1;
        tick();
        rob_mem_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (mem_wr !== 1'b0) $display("FAIL io_stall_%0d got mem_wr %b want 0", i, mem_wr);
            else passed++;
            if (i == 2) io_buffer_full = 1'b0;
            tick();
        end
        total++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h30000 || mem_dout !== 8'h41 || mem_store_done !== 1'b0)
            $display("FAIL io_write got wr %b a %h d %h done %b want 1 30000 41 0",
                     mem_wr, mem_a, mem_dout, mem_store_done);
        else passed++;
        tick();
        total++;
        if (mem_wr !== 1'b0 || mem_store_done !== 1'b1)
            $display("FAIL io_done got wr %b done %b want 0 1", mem_wr, mem_store_done);
        else passed++;
        tick();
        total++;
        if (mem_store_done !== 1'b0) $display("FAIL io_done_pulse got %b want 0", mem_store_done);
        else passed++;
    endtask

    task automatic test_async_reset();
        rob_mem_op = OP_SW; rob_mem_addr = 32'h3000; rob_mem_data = 32'h12345678; rob_mem_enable = 1'b1;
        tick();
        rob_mem_enable = 1'b0;
        tick();
        total++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h3001) $display("FAIL mid_sw got wr %b a %h want 1 3001", mem_wr, mem_a);
        else passed++;
        #2 rst = 1'b0;
        #1;
        total++;
        if (mem_wr !== 1'b0 || mem_a !== 32'h0 || mem_dout !== 8'h0 || mem_busy !== 1'b0)
            $display("FAIL async_rst got wr %b a %h d %h busy %b want 0 0 0 0", mem_wr, mem_a, mem_dout, mem_busy);
        else passed++;
        tick();
        rst = 1'b1;
        tick();
        run_load(OP_LW, 32'h1000, 4'd9, 32'h44332211, 5, "post_rst_lw");
    endtask

    initial begin
        ram[32'h1000] = 8'h11; ram[32'h1001] = 8'h22; ram[32'h1002] = 8'h33; ram[32'h1003] = 8'h44;
        ram[32'h20] = 8'h80;
        ram[32'h40] = 8'h01; ram[32'h41] = 8'h80;
        test_reset();
        test_loads();
        test_back_to_back();
        test_flush();
        test_io_store();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
